// File: rtl/coupler_x2_pkg.sv
//------------------------------------------------------------------------------
// coupler_x2_pkg : shared tuple constants, FSM states and terminator test.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package coupler_x2_pkg;

  localparam int C_TUPLE_W    = 128;
  localparam int C_MAX_WORD_W = 4096;

  localparam logic [C_MAX_WORD_W-1:0] C_TERM_WORD = '0;

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_t;

  // A word ends a run when its tuple 0 (lowest tuple_w bits) is all zero.
  function automatic logic is_term(input logic [C_MAX_WORD_W-1:0] word,
                                   input int unsigned tuple_w);
    logic [C_MAX_WORD_W-1:0] mask;
    if (tuple_w >= C_MAX_WORD_W)
      mask = '1;
    else
      mask = (C_MAX_WORD_W'(1) << tuple_w) - C_MAX_WORD_W'(1);
    return (word & mask) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coupler_x2_fwft_fifo2.sv
//------------------------------------------------------------------------------
// fwft_fifo2 : 2-entry first-word-fall-through buffer, pushes 0/1/2 per cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fwft_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_push_n,
  input  logic [WIDTH-1:0] i_din0,
  input  logic [WIDTH-1:0] i_din1,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_count;

  logic             w_pop;
  logic [1:0]       w_keep;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_next0;
  logic [WIDTH-1:0] w_next1;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_keep = r_count - {1'b0, w_pop};
  // With one entry surviving the pop, it is the old second slot if we popped.
  assign w_rem  = w_pop ? r_mem1 : r_mem0;

  always_comb begin
    w_next0 = r_mem0;
    w_next1 = r_mem1;
    case (w_keep)
      2'd0: begin
        w_next0 = i_din0;
        w_next1 = i_din1;
      end
      2'd1: begin
        w_next0 = w_rem;
        w_next1 = i_din0;
      end
      default: begin
        w_next0 = r_mem0;
        w_next1 = r_mem1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else begin
      r_mem0  <= w_next0;
      r_mem1  <= w_next1;
      r_count <= w_keep + i_push_n;
    end
  end

  assign o_dout  = r_mem0;
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/coupler_x2.sv
//------------------------------------------------------------------------------
// coupler_x2 : packs pairs of P-tuple FWFT words into 2P-tuple FWFT words.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module coupler_x2
  import coupler_x2_pkg::*;
#(
  parameter int DATA_WIDTH = C_TUPLE_W,
  parameter int IN_TUPLES  = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [IN_TUPLES*DATA_WIDTH-1:0]   i_data,
  input  logic                              i_empty,
  output logic                              o_read,
  output logic [2*IN_TUPLES*DATA_WIDTH-1:0] o_data,
  output logic                              o_empty,
  input  logic                              i_read,
  output logic [31:0]                       o_runs
);

  localparam int IW = IN_TUPLES * DATA_WIDTH;
  localparam int OW = 2 * IW;

  pack_state_t r_state;
  logic [IW-1:0] r_half;
  logic [31:0]   r_runs;

  logic          w_term;
  logic [1:0]    w_count;
  logic          w_buf_empty;
  logic          w_pop;
  logic [1:0]    w_free;
  logic          w_need_two;
  logic [1:0]    w_push_n;
  logic [OW-1:0] w_din0;
  logic [OW-1:0] w_din1;

  assign w_term     = is_term(C_MAX_WORD_W'(i_data), DATA_WIDTH);
  assign w_pop      = i_read & ~w_buf_empty;
  assign w_free     = 2'd2 - (w_count - {1'b0, w_pop});
  // Closing an odd run emits two words at once, so it needs the whole buffer.
  assign w_need_two = (r_state == ST_HIGH) & w_term;
  assign o_read     = ~i_rst & ~i_empty &
                      (w_need_two ? (w_free == 2'd2) : (w_free != 2'd0));

  always_comb begin
    w_push_n = 2'd0;
    w_din0   = C_TERM_WORD[OW-1:0];
    w_din1   = C_TERM_WORD[OW-1:0];
    if (o_read) begin
      if (r_state == ST_LOW) begin
        if (w_term) w_push_n = 2'd1;
      end else if (w_term) begin
        w_push_n = 2'd2;
        w_din0   = {{IW{1'b0}}, r_half};
      end else begin
        w_push_n = 2'd1;
        w_din0   = {i_data, r_half};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LOW;
      r_half  <= '0;
      r_runs  <= 32'd0;
    end else if (o_read) begin
      if (w_term) begin
        r_state <= ST_LOW;
        r_runs  <= r_runs + 32'd1;
      end else if (r_state == ST_LOW) begin
        r_half  <= i_data;
        r_state <= ST_HIGH;
      end else begin
        r_state <= ST_LOW;
      end
    end
  end

  fwft_fifo2 #(
    .WIDTH (OW)
  ) u_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push_n (w_push_n),
    .i_din0   (w_din0),
    .i_din1   (w_din1),
    .i_pop    (i_read),
    .o_dout   (o_data),
    .o_count  (w_count),
    .o_empty  (w_buf_empty)
  );

  assign o_empty = w_buf_empty;
  assign o_runs  = r_runs;

endmodule

`default_nettype wire

// File: tb/tb_coupler_x2.sv
//------------------------------------------------------------------------------
// tb_coupler_x2 : queue-based reference model plus directed pins and random runs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_coupler_x2;

  localparam int DW = 8;
  localparam int NT = 2;
  localparam int IW = DW * NT;
  localparam int OW = 2 * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] i_data;
  logic          i_empty;
  logic          o_read;
  logic [OW-1:0] o_data;
  logic          o_empty;
  logic          i_read;
  logic [31:0]   o_runs;

  always #5 clk = ~clk;

  coupler_x2 #(
    .DATA_WIDTH (DW),
    .IN_TUPLES  (NT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (i_data),
    .i_empty (i_empty),
    .o_read  (o_read),
    .o_data  (o_data),
    .o_empty (o_empty),
    .i_read  (i_read),
    .o_runs  (o_runs)
  );

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] q_in[$];
  logic [OW-1:0] q_out[$];
  logic [OW-1:0] drained[$];
  logic          half_v;
  logic [IW-1:0] half;
  logic [31:0]   runs;
  logic          last_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic model_read();
    int  occ;
    int  need;
    logic term;
    if (rst || i_empty) return 1'b0;
    occ  = q_out.size() - ((i_read && q_out.size() > 0) ? 1 : 0);
    term = (i_data[DW-1:0] == '0);
    need = (half_v && term) ? 2 : 1;
    return (2 - occ) >= need;
  endfunction

  task automatic cycle(input int rd_pct, input int stall_pct, input bit do_rst = 1'b0);
    logic er;
    logic [IW-1:0] w;
    rst     = do_rst;
    i_read  = ($urandom_range(99) < rd_pct);
    i_empty = (q_in.size() == 0) || ($urandom_range(99) < stall_pct);
    i_data  = i_empty ? IW'($urandom) : q_in[0];
    #1;
    er      = model_read();
    last_rd = o_read;
    chk("o_read", {63'd0, o_read}, {63'd0, er});
    if (!do_rst && i_read && !o_empty) drained.push_back(o_data);
    @(posedge clk);
    if (do_rst) begin
      q_out.delete();
      half_v = 1'b0;
      runs   = 32'd0;
    end else begin
      if (i_read && q_out.size() > 0) void'(q_out.pop_front());
      if (er) begin
        w = q_in.pop_front();
        if (w[DW-1:0] == '0) begin
          if (half_v) q_out.push_back({{IW{1'b0}}, half});
          q_out.push_back('0);
          runs++;
          half_v = 1'b0;
        end else if (!half_v) begin
          half   = w;
          half_v = 1'b1;
        end else begin
          q_out.push_back({w, half});
          half_v = 1'b0;
        end
      end
    end
    chk("no_overflow", 64'(q_out.size() <= 2), 64'd1);
    #1;
    chk("o_empty", {63'd0, o_empty}, {63'd0, (q_out.size() == 0)});
    if (q_out.size() > 0) chk("o_data", 64'(o_data), 64'(q_out[0]));
    chk("o_runs", 64'(o_runs), 64'(runs));
  endtask

  task automatic run(input int n, input int rd_pct);
    for (int k = 0; k < n; k++) cycle(rd_pct, 0);
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; i_empty = 1'b1; i_data = '0;
    half_v = 1'b0; half = '0; runs = 32'd0; last_rd = 1'b0;
    @(posedge clk); #1;
    cycle(0, 0, 1'b1);
    cycle(0, 0, 1'b1);
    chk("rst_empty", {63'd0, o_empty}, 64'd1);
    chk("rst_runs", 64'(o_runs), 64'd0);

    // pairs packed, upper half in the high bits
    q_in = '{16'h1A01, 16'h2A02, 16'h3A03, 16'h4A04};
    run(2, 100);
    chk("t1_w0", 64'(o_data), 64'h2A02_1A01);
    run(2, 100);
    chk("t1_w1", 64'(o_data), 64'h4A04_3A03);
    chk("t1_runs", 64'(o_runs), 64'd0);
    run(1, 100);

    // even run then terminator
    q_in = '{16'h1A01, 16'h2A02, 16'h5500};
    run(2, 100);
    chk("t2_w0", 64'(o_data), 64'h2A02_1A01);
    run(1, 100);
    chk("t2_term_vis", {63'd0, o_empty}, 64'd0);
    chk("t2_term", 64'(o_data), 64'h0);
    chk("t2_runs", 64'(o_runs), 64'd1);
    run(1, 100);

    // odd run padded with a zero half
    q_in = '{16'h1A01, 16'h7700};
    run(2, 100);
    chk("t3_pad", 64'(o_data), 64'h0000_1A01);
    run(1, 100);
    chk("t3_term", 64'(o_data), 64'h0);
    chk("t3_runs", 64'(o_runs), 64'd2);
    run(1, 100);

    // backpressure: only four words accepted, then drained in order
    q_in = '{16'h1A01, 16'h2A02, 16'h3A03, 16'h4A04, 16'h5A05, 16'h6A06};
    run(6, 0);
    chk("t4_left", 64'(q_in.size()), 64'd2);
    chk("t4_head", 64'(q_in[0]), 64'h5A05);
    drained.delete();
    run(6, 100);
    chk("t4_cnt", 64'(drained.size()), 64'd3);
    if (drained.size() == 3) begin
      chk("t4_d0", 64'(drained[0]), 64'h2A02_1A01);
      chk("t4_d1", 64'(drained[1]), 64'h4A04_3A03);
      chk("t4_d2", 64'(drained[2]), 64'h6A06_5A05);
    end

    // HIGH, one buffered, terminator at head needs two free slots
    q_in = '{16'h1A01, 16'h2A02, 16'h3A03, 16'h8800};
    run(3, 0);
    run(1, 0);
    chk("t5_hold", {63'd0, last_rd}, 64'd0);
    run(1, 100);
    chk("t5_pop", {63'd0, last_rd}, 64'd1);
    chk("t5_w", 64'(o_data), 64'h0000_3A03);
    run(3, 100);

    // reset mid-operation discards half and buffer
    q_in = '{16'h1A01, 16'h2A02, 16'h3A03};
    run(3, 0);
    cycle(0, 0, 1'b1);
    chk("t6_empty", {63'd0, o_empty}, 64'd1);
    chk("t6_runs", 64'(o_runs), 64'd0);
    q_in = '{16'h1B01, 16'h2B02};
    run(2, 0);
    chk("t6_w", 64'(o_data), 64'h2B02_1B01);
    run(2, 100);

    // randomized traffic against the model
    for (int ph = 0; ph < 4; ph++) begin
      int rdp, stp;
      rdp = (ph == 0) ? 100 : (ph == 1) ? 50 : (ph == 2) ? 10 : 80;
      stp = (ph == 0) ? 0   : (ph == 1) ? 30 : (ph == 2) ? 50 : 10;
      for (int k = 0; k < 2000; k++) begin
        while (q_in.size() < 4) begin
          logic [DW-1:0] t0;
          t0 = ($urandom_range(99) < 25) ? '0 : DW'($urandom_range(1, 255));
          q_in.push_back({DW'($urandom), t0});
        end
        cycle(rdp, stp, (ph == 3 && k == 1000));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
